// File: rtl/fifo_pkg.sv
// fifo_pkg: status bundle and threshold sanity check shared by the FIFO family.
package fifo_pkg;

    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic almost_full;
        logic full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic bit th_ok(input int aw, input int afull_th, input int aempty_th);
        return afull_th >= 1 && afull_th <= (1 << aw) && aempty_th >= 0 && aempty_th <= (1 << aw) - 1;
    endfunction

endpackage

// File: rtl/SdpRamRf.sv
// SdpRamRf: simple dual-port register-file RAM, port A writes, port B reads with a registered output.
module SdpRamRf #(
    parameter int DW    = 8,
    parameter int WORDS = 1024
) (
    input  logic                     clk,
    input  logic                     i_a_we,
    input  logic [$clog2(WORDS)-1:0] i_a_addr,
    input  logic [DW-1:0]            i_a_din,
    input  logic                     i_b_re,
    input  logic [$clog2(WORDS)-1:0] i_b_addr,
    output logic [DW-1:0]            o_b_dout
);

    logic [DW-1:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (i_a_we) r_mem[i_a_addr] <= i_a_din;
        if (i_b_re) o_b_dout <= r_mem[i_b_addr];
    end

endmodule

// File: rtl/sc_fifo_fwft.sv
// sc_fifo_fwft: single-clock first-word-fall-through FIFO over a registered-output RAM,
// with programmable almost flags, sticky error flags and a synchronous flush.
module sc_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DW        = 8,
    parameter int AW        = 10,
    parameter int AFULL_TH  = 2**AW - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic [DW-1:0] i_din,
    input  logic          i_write,
    input  logic          i_read,
    output logic [DW-1:0] o_dout,
    output logic [AW:0]   o_data_cnt,
    output logic          o_full,
    output logic          o_almost_full,
    output logic          o_empty,
    output logic          o_almost_empty,
    output logic          o_overflow,
    output logic          o_underflow
);

    localparam int DEPTH = 1 << AW;

    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [DW-1:0] data_t;

    if (!th_ok(AW, AFULL_TH, AEMPTY_TH)) begin : g_bad_th
        $error("sc_fifo_fwft: AFULL_TH/AEMPTY_TH out of range");
    end

    addr_t r_wr_ptr, r_rd_ptr;
    cnt_t  r_data_cnt, r_ram_cnt;
    logic  r_out_valid, r_fetch_dly, r_overflow, r_underflow;
    data_t r_hold, w_ram_dout;
    logic  w_full, w_wr_acc, w_rd_acc, w_fetch;
    fifo_status_t w_st;

    assign w_full   = r_data_cnt == cnt_t'(DEPTH);
    assign w_wr_acc = i_write & ~w_full & ~i_clear;
    assign w_rd_acc = i_read & r_out_valid & ~i_clear;
    // Refill the output stage whenever it is empty or being consumed this cycle.
    assign w_fetch  = (r_ram_cnt != '0) & (~r_out_valid | w_rd_acc) & ~i_clear;

    SdpRamRf #(.DW(DW), .WORDS(DEPTH)) u_ram (
        .clk      (clk),
        .i_a_we   (w_wr_acc),
        .i_a_addr (r_wr_ptr),
        .i_a_din  (i_din),
        .i_b_re   (w_fetch),
        .i_b_addr (r_rd_ptr),
        .o_b_dout (w_ram_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || i_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_data_cnt  <= '0;
            r_ram_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_fetch_dly <= 1'b0;
            r_hold      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= r_wr_ptr + addr_t'(w_wr_acc);
            r_rd_ptr    <= r_rd_ptr + addr_t'(w_fetch);
            r_data_cnt  <= r_data_cnt + cnt_t'(w_wr_acc) - cnt_t'(w_rd_acc);
            r_ram_cnt   <= r_ram_cnt + cnt_t'(w_wr_acc) - cnt_t'(w_fetch);
            r_out_valid <= w_fetch | (r_out_valid & ~w_rd_acc);
            r_fetch_dly <= w_fetch;
            r_hold      <= r_fetch_dly ? w_ram_dout : r_hold;
            r_overflow  <= r_overflow | (i_write & w_full);
            r_underflow <= r_underflow | (i_read & ~r_out_valid);
        end
    end

    assign w_st = '{
        empty:        ~r_out_valid,
        almost_empty: r_data_cnt <= cnt_t'(AEMPTY_TH),
        almost_full:  r_data_cnt >= cnt_t'(AFULL_TH),
        full:         w_full,
        overflow:     r_overflow,
        underflow:    r_underflow
    };

    assign o_dout         = r_fetch_dly ? w_ram_dout : r_hold;
    assign o_data_cnt     = r_data_cnt;
    assign o_full         = w_st.full;
    assign o_almost_full  = w_st.almost_full;
    assign o_empty        = w_st.empty;
    assign o_almost_empty = w_st.almost_empty;
    assign o_overflow     = w_st.overflow;
    assign o_underflow    = w_st.underflow;

endmodule

// File: tb/tb_sc_fifo_fwft.sv
// tb_sc_fifo_fwft: scoreboard bench for sc_fifo_fwft at AW=3, DW=8, thresholds 6/1.
module tb_sc_fifo_fwft;

    logic       clk = 1'b0, rst_n = 1'b0, i_clear = 1'b0, i_write = 1'b0, i_read = 1'b0;
    logic [7:0] i_din = '0, o_dout;
    logic [3:0] o_data_cnt;
    logic       o_full, o_almost_full, o_empty, o_almost_empty, o_overflow, o_underflow;

    sc_fifo_fwft #(.DW(8), .AW(3), .AFULL_TH(6), .AEMPTY_TH(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_clear        (i_clear),
        .i_din          (i_din),
        .i_write        (i_write),
        .i_read         (i_read),
        .o_dout         (o_dout),
        .o_data_cnt     (o_data_cnt),
        .o_full         (o_full),
        .o_almost_full  (o_almost_full),
        .o_empty        (o_empty),
        .o_almost_empty (o_almost_empty),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         e;
    } ent_t;

    ent_t sb[$];
    int   n_tests = 0, n_fail = 0, edge_n = 0, m_cnt = 0;
    logic m_ovf = 1'b0, m_unf = 1'b0;

    // A word is on dout from the second edge after its write, once everything ahead of it is popped.
    function automatic logic m_empty();
        return sb.size() == 0 || sb[0].e + 1 > edge_n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic check_all();
        chk("empty", 32'(o_empty), 32'(m_empty()));
        chk("data_cnt", 32'(o_data_cnt), 32'(m_cnt));
        chk("full", 32'(o_full), 32'(m_cnt == 8));
        chk("almost_full", 32'(o_almost_full), 32'(m_cnt >= 6));
        chk("almost_empty", 32'(o_almost_empty), 32'(m_cnt <= 1));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        chk("underflow", 32'(o_underflow), 32'(m_unf));
        if (!m_empty()) chk("dout", 32'(o_dout), 32'(sb[0].d));
    endtask

    task automatic step(input logic wr, input logic rd, input logic clr, input logic [7:0] d);
        logic full_m, empty_m;
        i_write = wr;
        i_read  = rd;
        i_clear = clr;
        i_din   = d;
        full_m  = m_cnt == 8;
        empty_m = m_empty();
        @(posedge clk);
        edge_n++;
        if (clr) begin
            sb.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (wr && full_m) m_ovf = 1'b1;
            if (rd && empty_m) m_unf = 1'b1;
            if (rd && !empty_m) begin
                void'(sb.pop_front());
                m_cnt--;
            end
            if (wr && !full_m) begin
                sb.push_back(ent_t'{d, edge_n});
                m_cnt++;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        i_write = 1'b0;
        i_read  = 1'b0;
        i_clear = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_dout", 32'(o_dout), 32'd0);
        chk("rst_data_cnt", 32'(o_data_cnt), 32'd0);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_almost_full", 32'(o_almost_full), 32'd0);
        chk("rst_almost_empty", 32'(o_almost_empty), 32'd1);
        chk("rst_overflow", 32'(o_overflow), 32'd0);
        chk("rst_underflow", 32'(o_underflow), 32'd0);
        sb.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("init_dout", 32'(o_dout), 32'd0);
        check_all();
        rst_n = 1'b1;
        step(1, 0, 0, 8'h11);
        step(0, 0, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 8'(i));
        step(1, 0, 0, 8'hEE);
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 9; i++) step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h20);
        step(1, 0, 0, 8'h21);
        step(1, 0, 0, 8'h22);
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 8'(8'h30 + i));
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h50 + i));
        step(1, 0, 0, 8'hEE);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
        step(1, 0, 1, 8'h77);
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'h60 + i));
        step(1, 1, 0, 8'h63);
        async_reset();
        step(1, 0, 0, 8'hA5);
        step(0, 0, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0, 8'($urandom));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
